sr_cmd_sequencer: RTL and testbench

- Upstream command stage for the SR flip-flop. Accepts set/reset requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the flip-flop's 2-bit sr input with clean, fixed-width command pulses separated by hold (00) cycles. Never issues the illegal 2'b11 code.
- Keeps a shadow copy of the expected flip-flop state and flags any divergence from the fed-back q.

---
 rtl/sr_cmd_sequencer_if.sv | 29 ++
 rtl/sr_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// sr_cmd_sequencer_if
// Request handshake between a command producer and sr_cmd_sequencer.
//   req_valid : producer has a request this cycle
//   req_ready : sequencer can accept a request this cycle
//   req_s     : set request bit
//   req_r     : reset request bit
// A request is taken on a rising clock edge where req_valid & req_ready.
// -----------------------------------------------------------------------------
interface sr_cmd_sequencer_if;
    logic req_valid;
    logic req_ready;
    logic req_s;
    logic req_r;

    modport master (
        output req_valid,
        output req_s,
        output req_r,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_s,
        input  req_r,
        output req_ready
    );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sr_cmd_sequencer
// Upstream command stage for an SR flip-flop. Requests arrive over a
// valid/ready handshake, are queued in a small circular FIFO and are replayed
// to the flip-flop as fixed-width pulses on sr, each followed by one 00 gap
// cycle. A shadow of the expected flip-flop state is compared against the
// fed-back q during every gap cycle; any divergence sets a sticky flag.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      if   request handshake (slave side)
//   sr       out  registered {s,r} command; never 2'b11
//   q_fb     in   flip-flop q fed back
//   shadow_q out  expected flip-flop state
//   mismatch out  sticky: q_fb disagreed with shadow_q in a gap cycle
//   conflict out  one-cycle pulse after a 11 request was accepted
//   busy     out  FSM not idle or FIFO not empty
//   level    out  FIFO occupancy
// -----------------------------------------------------------------------------
module sr_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int HOLD     = 2,
    parameter int SET_WINS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    sr_cmd_sequencer_if.slave          req,
    output logic [1:0]                 sr,
    input  logic                       q_fb,
    output logic                       shadow_q,
    output logic                       mismatch,
    output logic                       conflict,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // FIFO entries hold a single bit (1 = set, 0 = reset), so a stored
    // command can only ever expand to 10 or 01 on sr.
    logic            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cmd_q, cmd_d;
    logic [1:0]      sr_q, sr_d;
    logic            shadow_q_q, shadow_q_d;
    logic            mismatch_q, mismatch_d;
    logic            conflict_q, conflict_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            req_set_s;

    // Handshake decode and conflict resolution of the incoming request.
    always_comb begin
        accept_s   = req.req_valid & ready_q;
        push_s     = accept_s & (req.req_s | req.req_r);
        conflict_d = accept_s & req.req_s & req.req_r;
        if (req.req_s && req.req_r) begin
            req_set_s = (SET_WINS != 0);
        end else begin
            req_set_s = req.req_s;
        end
    end

    // Command FSM: next state, sr command, shadow tracking and mismatch check.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        sr_d       = 2'b00;
        shadow_q_d = shadow_q_q;
        mismatch_d = mismatch_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != {LW{1'b0}}) begin
                    pop_s   = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    cnt_d   = CW'(HOLD - 1);
                    sr_d    = {cmd_d, ~cmd_d};
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d    = ST_GAP;
                    sr_d       = 2'b00;
                    shadow_q_d = cmd_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    sr_d  = {cmd_q, ~cmd_q};
                end
            end
            ST_GAP: begin
                mismatch_d = mismatch_q | (q_fb != shadow_q_q);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy update and the registered status outputs.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Ready follows the post-edge level, so a pop on a full FIFO does not
        // open the door in the same cycle.
        ready_d = (level_d != LW'(DEPTH));
        busy_d  = (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
    end

    // FIFO storage write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= req_set_s;
        end
    end

    // State, FIFO pointers and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            cmd_q      <= 1'b0;
            sr_q       <= 2'b00;
            shadow_q_q <= 1'b0;
            mismatch_q <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            sr_q       <= sr_d;
            shadow_q_q <= shadow_q_d;
            mismatch_q <= mismatch_d;
            conflict_q <= conflict_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    assign req.req_ready = ready_q;
    assign sr            = sr_q;
    assign shadow_q      = shadow_q_q;
    assign mismatch      = mismatch_q;
    assign conflict      = conflict_q;
    assign busy          = busy_q;
    assign level         = level_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_sequencer
// Directed bench for sr_cmd_sequencer (DEPTH=4, HOLD=2). A second instance
// built with SET_WINS=0 covers the other conflict resolution. Each sequencer
// drives a behavioural SR flip-flop whose q is fed back.
// -----------------------------------------------------------------------------
module tb_sr_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] sr0, sr1;
    logic       q_fb0, q_fb1;
    logic       shadow0, shadow1;
    logic       mismatch0, mismatch1;
    logic       conflict0, conflict1;
    logic       busy0, busy1;
    logic [2:0] level0, level1;
    logic       ff_q0, ff_q1;
    logic       fb_force;

    int n_cmp;
    int n_err;

    sr_cmd_sequencer_if if0 ();
    sr_cmd_sequencer_if if1 ();

    sr_cmd_sequencer #(.DEPTH(4), .HOLD(2), .SET_WINS(1)) u0 (
        .clk(clk), .rst(rst), .req(if0.slave), .sr(sr0), .q_fb(q_fb0),
        .shadow_q(shadow0), .mismatch(mismatch0), .conflict(conflict0),
        .busy(busy0), .level(level0)
    );

    sr_cmd_sequencer #(.DEPTH(4), .HOLD(2), .SET_WINS(0)) u1 (
        .clk(clk), .rst(rst), .req(if1.slave), .sr(sr1), .q_fb(q_fb1),
        .shadow_q(shadow1), .mismatch(mismatch1), .conflict(conflict1),
        .busy(busy1), .level(level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SR flip-flops, cleared while rst is low.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q0 <= 1'b0;
            ff_q1 <= 1'b0;
        end else begin
            if (sr0 == 2'b10) ff_q0 <= 1'b1;
            else if (sr0 == 2'b01) ff_q0 <= 1'b0;
            if (sr1 == 2'b10) ff_q1 <= 1'b1;
            else if (sr1 == 2'b01) ff_q1 <= 1'b0;
        end
    end

    assign q_fb0 = fb_force ? 1'b0 : ff_q0;
    assign q_fb1 = ff_q1;

    // Pulse recorder on u0: value and width of each non-zero run on sr.
    logic       mon_en;
    logic [1:0] prev_sr;
    logic [1:0] pulse_val [16];
    int         pulse_len [16];
    int         np;
    int         bad_gap;
    int         saw11;
    int         max_lvl;

    always @(negedge clk) begin
        if (!mon_en) begin
            np      <= 0;
            bad_gap <= 0;
            saw11   <= 0;
            max_lvl <= 0;
            prev_sr <= 2'b00;
        end else begin
            prev_sr <= sr0;
            if (int'(level0) > max_lvl) max_lvl <= int'(level0);
            if (sr0 == 2'b11) saw11 <= saw11 + 1;
            if (sr0 != 2'b00) begin
                if (prev_sr == 2'b00) begin
                    if (np < 16) begin
                        pulse_val[np] <= sr0;
                        pulse_len[np] <= 1;
                        np <= np + 1;
                    end
                end else if (prev_sr == sr0) begin
                    if (np > 0) pulse_len[np-1] <= pulse_len[np-1] + 1;
                end else begin
                    bad_gap <= bad_gap + 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request on if0 and hold it until accepted (bounded).
    task automatic push_one(input logic s, input logic r, output int waits);
        logic rdy;
        logic done;
        if0.req_valid = 1'b1;
        if0.req_s     = s;
        if0.req_r     = r;
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = if0.req_ready;
            tick();
            if (rdy) done = 1'b1;
            else     waits++;
        end
        if0.req_valid = 1'b0;
        chk("push_accepted", {7'd0, done}, 8'd1);
    endtask

    logic [1:0] seq [6];
    int         w;
    int         stall_total;

    initial begin
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        fb_force = 1'b0;
        rst = 1'b0;
        if0.req_valid = 1'b1; if0.req_s = 1'b1; if0.req_r = 1'b0;
        if1.req_valid = 1'b0; if1.req_s = 1'b0; if1.req_r = 1'b0;
        seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10;
        seq[3] = 2'b01; seq[4] = 2'b10; seq[5] = 2'b01;

        // Reset held with a valid request pending.
        repeat (3) tick();
        chk("rst_sr",       {6'd0, sr0},       8'd0);
        chk("rst_shadow",   {7'd0, shadow0},   8'd0);
        chk("rst_mismatch", {7'd0, mismatch0}, 8'd0);
        chk("rst_level",    {5'd0, level0},    8'd0);
        chk("rst_ready",    {7'd0, if0.req_ready}, 8'd0);
        chk("rst_busy",     {7'd0, busy0},     8'd0);
        rst = 1'b1;
        if0.req_valid = 1'b0;
        tick();
        chk("rel_ready",    {7'd0, if0.req_ready}, 8'd1);
        chk("rel_level",    {5'd0, level0},    8'd0);

        // Single set command.
        if0.req_valid = 1'b1; if0.req_s = 1'b1; if0.req_r = 1'b0;
        tick();
        if0.req_valid = 1'b0;
        chk("set_level_n",  {5'd0, level0},    8'd1);
        chk("set_busy_n",   {7'd0, busy0},     8'd1);
        chk("set_sr_n",     {6'd0, sr0},       8'd0);
        tick();
        chk("set_sr_n1",    {6'd0, sr0},       8'h2);
        chk("set_level_n1", {5'd0, level0},    8'd0);
        tick();
        chk("set_sr_n2",    {6'd0, sr0},       8'h2);
        chk("set_shadow_n2",{7'd0, shadow0},   8'd0);
        tick();
        chk("set_sr_n3",    {6'd0, sr0},       8'h0);
        chk("set_shadow_n3",{7'd0, shadow0},   8'd1);
        chk("set_busy_n3",  {7'd0, busy0},     8'd1);
        tick();
        chk("set_busy_n4",  {7'd0, busy0},     8'd0);
        chk("set_mism_n4",  {7'd0, mismatch0}, 8'd0);

        // Conflicting request on both instances.
        if0.req_valid = 1'b1; if0.req_s = 1'b1; if0.req_r = 1'b1;
        if1.req_valid = 1'b1; if1.req_s = 1'b1; if1.req_r = 1'b1;
        tick();
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        chk("cfl_pulse_sw1",  {7'd0, conflict0}, 8'd1);
        chk("cfl_pulse_sw0",  {7'd0, conflict1}, 8'd1);
        tick();
        chk("cfl_end_sw1",    {7'd0, conflict0}, 8'd0);
        chk("cfl_end_sw0",    {7'd0, conflict1}, 8'd0);
        chk("cfl_sr_sw1",     {6'd0, sr0},       8'h2);
        chk("cfl_sr_sw0",     {6'd0, sr1},       8'h1);
        repeat (3) tick();
        chk("cfl_idle_sw1",   {7'd0, busy0},     8'd0);
        chk("cfl_idle_sw0",   {7'd0, busy1},     8'd0);
        chk("cfl_mism_sw0",   {7'd0, mismatch1}, 8'd0);

        // Null request is accepted and dropped.
        if0.req_valid = 1'b1; if0.req_s = 1'b0; if0.req_r = 1'b0;
        tick();
        if0.req_valid = 1'b0;
        chk("nul_level",    {5'd0, level0},    8'd0);
        chk("nul_busy",     {7'd0, busy0},     8'd0);
        chk("nul_conflict", {7'd0, conflict0}, 8'd0);
        tick();
        chk("nul_sr",       {6'd0, sr0},       8'd0);

        // Fill past DEPTH and check ordering/spacing of the replayed pulses.
        mon_en = 1'b1;
        stall_total = 0;
        for (int i = 0; i < 6; i++) begin
            push_one(seq[i][1], seq[i][0], w);
            stall_total += w;
            if (i == 4) begin
                chk("full_level", {5'd0, level0}, 8'd4);
                chk("full_ready", {7'd0, if0.req_ready}, 8'd0);
            end
        end
        chk("full_stalls", 8'(stall_total), 8'd1);
        repeat (40) tick();
        chk("ord_count", 8'(np), 8'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ord_val%0d", i), {6'd0, pulse_val[i]}, {6'd0, seq[i]});
            chk($sformatf("ord_len%0d", i), 8'(pulse_len[i]), 8'd2);
        end
        chk("ord_no_gap", 8'(bad_gap), 8'd0);
        chk("ord_no_11",  8'(saw11),   8'd0);
        chk("ord_maxlvl", 8'(max_lvl), 8'd4);
        chk("ord_idle",   {7'd0, busy0}, 8'd0);
        chk("ord_mism",   {7'd0, mismatch0}, 8'd0);
        mon_en = 1'b0;

        // Broken feedback during a set command.
        fb_force = 1'b1;
        if0.req_valid = 1'b1; if0.req_s = 1'b1; if0.req_r = 1'b0;
        tick();
        if0.req_valid = 1'b0;
        repeat (3) tick();
        chk("mis_before_gap", {7'd0, mismatch0}, 8'd0);
        tick();
        chk("mis_after_gap",  {7'd0, mismatch0}, 8'd1);
        fb_force = 1'b0;
        if0.req_valid = 1'b1; if0.req_s = 1'b0; if0.req_r = 1'b1;
        tick();
        if0.req_valid = 1'b0;
        repeat (5) tick();
        chk("mis_sticky",     {7'd0, mismatch0}, 8'd1);
        chk("mis_shadow",     {7'd0, shadow0},   8'd0);

        // Reset while driving with three commands queued.
        for (int i = 0; i < 5; i++) begin
            push_one(seq[i][1], seq[i][0], w);
        end
        tick();
        chk("mid_level", {5'd0, level0}, 8'd3);
        chk("mid_sr",    {6'd0, sr0},    8'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_sr",     {6'd0, sr0},       8'd0);
        chk("mid_rst_level",  {5'd0, level0},    8'd0);
        chk("mid_rst_busy",   {7'd0, busy0},     8'd0);
        chk("mid_rst_mism",   {7'd0, mismatch0}, 8'd0);
        chk("mid_rst_shadow", {7'd0, shadow0},   8'd0);
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (20) tick();
        chk("post_rst_pulses", 8'(np), 8'd0);
        chk("post_rst_level",  {5'd0, level0}, 8'd0);
        chk("post_rst_busy",   {7'd0, busy0},  8'd0);
        chk("post_rst_ready",  {7'd0, if0.req_ready}, 8'd1);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
